dm_arbiter: RTL and testbench
=============================

# dm_arbiter

Single-port data-memory arbiter placed between the CPU datapath, the debug/switch read path and the DM macro. The CPU normally owns the DM port with combinational reads and clock-edge writes. Debug reads are queued and served either in cycles when the CPU does not use memory, or by forcing a one-cycle CPU stall once a starvation limit is reached. This replaces the static stop-gated address mux.

## Interface
Parameters:
- ADDR_W, 10, DM word-address width (matches switch_in)
- DATA_W, 32, data width
- STARVE_MAX, 4, number of consecutive denied cycles a pending debug read tolerates before it is forced (1..15)

Ports:
- clk  in  1  system clock; all state updates on posedge
- rst  in  1  reset, asynchronous, active-low (0 = reset)
- cpu_re  in  1  CPU load this cycle (MemRead)
- cpu_we  in  1  CPU store this cycle (MemWrite)
- cpu_addr  in  ADDR_W  CPU word address (alu_out slice)
- cpu_wdata  in  DATA_W  store data
- cpu_rdata  out  DATA_W  load data, combinational from dm_rdata
- cpu_stall  out  1  CPU must hold its PC and suppress RegWrite this cycle
- dbg_req  in  1  debug read request; sampled on posedge
- dbg_addr  in  ADDR_W  debug address; captured with dbg_req
- dbg_busy  out  1  a debug read is pending
- dbg_rdata  out  DATA_W  registered debug read data
- dbg_valid  out  1  one-cycle pulse when dbg_rdata has been updated
- dm_addr  out  ADDR_W  to DM
- dm_wdata  out  DATA_W  to DM
- dm_re  out  1  to DM
- dm_we  out  1  to DM
- dm_rdata  in  DATA_W  from DM, combinational read

## Operation
- Register state: pend (1b), pend_addr, starve (4b), dbg_rdata, dbg_valid.
- Capture: on a posedge where dbg_req=1 and pend=0: pend<=1, pend_addr<=dbg_addr, starve<=0. A dbg_req while pend=1 is ignored, with no queueing. dbg_busy=pend.
- Grant decision is combinational per cycle, with cpu_use = cpu_re|cpu_we:
  - pend=0: CPU owns the port.
  - pend=1, cpu_use=0: debug granted (free slot), no stall.
  - pend=1, cpu_use=1, starve<STARVE_MAX: CPU owns the port and starve increments on the edge.
  - pend=1, cpu_use=1, starve==STARVE_MAX: debug granted (forced) and cpu_stall=1.
- CPU grant: dm_addr=cpu_addr, dm_wdata=cpu_wdata, dm_re=cpu_re, dm_we=cpu_we.
- Debug grant: dm_addr=pend_addr, dm_re=1, dm_we=0, dm_wdata=0.
- On a debug-granted edge: dbg_rdata<=dm_rdata, dbg_valid<=1, pend<=0, starve<=0. On every other edge dbg_valid<=0.
- Same-edge capture: a dbg_req on the same edge that completes a grant is accepted, so pend stays 1 with the new address.
- cpu_rdata=dm_rdata always. The value is meaningless while cpu_stall=1.
- The CPU never writes while stalled. dm_we is 0 in every debug-granted cycle.
- starve saturates at STARVE_MAX. There is no wrap.

## Timing
- Reset values (asynchronous): pend=0, pend_addr=0, starve=0, dbg_rdata=0, dbg_valid=0. Combinational outputs then follow the CPU grant, and cpu_stall=0.
- Latency from dbg_req to dbg_valid:
  - Minimum 2 edges: capture, then a free-slot grant.
  - Maximum STARVE_MAX+2 edges under continuous CPU memory traffic.
- cpu_stall is combinational: it is high for exactly one cycle per forced grant, and never for two consecutive cycles.
- Reset asserted mid-request drops the pending read with no dbg_valid pulse.

## Configuration
- DM_ARB_STATS_EN defined: adds outputs stall_cnt[15:0] and dbg_cnt[15:0].
  - Both are saturating counters, reset to 0 by rst.
  - stall_cnt increments on each forced grant; dbg_cnt increments on each debug grant.
- Undefined: the ports and logic are absent. Arbitration behaviour is identical either way.

## Test plan
- Idle CPU: dbg_req with addr 0x005, DM[5]=0xDEADBEEF. Required: grant on the next cycle, dbg_valid pulse 2 edges after the request, dbg_rdata=0xDEADBEEF, cpu_stall never asserted.
- Continuous CPU loads, STARVE_MAX=4, debug addr 0x010. Required: cpu_stall high in exactly one cycle (the 5th after capture), dbg_valid on the following edge, and the CPU access in the stalled cycle not performed.
- CPU store to 0x020 (0x12345678) in the same cycle a debug read of 0x020 is granted in a free slot. This cannot happen because the CPU owns the port; check the store completes and a subsequent debug read returns 0x12345678.
- dbg_req held high for 3 cycles while pend=1. Required: only the first address is captured and a single dbg_valid pulse.
- Assert rst low while pend=1. Required: pend, starve and dbg_valid clear immediately (asynchronously), and no dbg_valid pulse follows release.
- With DM_ARB_STATS_EN: 3 forced grants plus 2 free-slot grants. Required: stall_cnt=3, dbg_cnt=5.

Source files
------------

// File: rtl/dm_arbiter.sv
// Single-port DM arbiter: the CPU owns the port; one pending debug read is served in a free
// slot or forced after STARVE_MAX denied cycles. DM_ARB_STATS_EN adds grant/stall counters.
module dm_arbiter #(
  parameter int ADDR_W     = 10,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_re,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_stall,
  input  logic              dbg_req,
  input  logic [ADDR_W-1:0] dbg_addr,
  output logic              dbg_busy,
  output logic [DATA_W-1:0] dbg_rdata,
  output logic              dbg_valid,
  output logic [ADDR_W-1:0] dm_addr,
  output logic [DATA_W-1:0] dm_wdata,
  output logic              dm_re,
  output logic              dm_we,
  input  logic [DATA_W-1:0] dm_rdata
`ifdef DM_ARB_STATS_EN
  ,
  output logic [15:0]       stall_cnt,
  output logic [15:0]       dbg_cnt
`endif
);

  typedef enum logic {S_IDLE, S_PEND} state_t;

  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] pend_addr_q, pend_addr_d;
  logic [3:0]        starve_q, starve_d;
  logic              pend, cpu_use, starve_full, dbg_grant, forced;

  always_comb begin
    pend        = (state_q == S_PEND);
    cpu_use     = cpu_re | cpu_we;
    starve_full = (starve_q == STARVE_LIM);
    dbg_grant   = pend && (!cpu_use || starve_full);
    forced      = pend && cpu_use && starve_full;

    state_d     = state_q;
    pend_addr_d = pend_addr_q;
    starve_d    = starve_q;

    // A grant frees the slot, so a request on the same edge is captured immediately.
    if (!pend || dbg_grant) begin
      starve_d = '0;
      if (dbg_req) begin
        state_d     = S_PEND;
        pend_addr_d = dbg_addr;
      end else begin
        state_d = S_IDLE;
      end
    end else if (!starve_full) begin
      starve_d = starve_q + 4'd1;
    end

    cpu_stall = forced;
    dbg_busy  = pend;
    cpu_rdata = dm_rdata;

    if (dbg_grant) begin
      dm_addr  = pend_addr_q;
      dm_wdata = '0;
      dm_re    = 1'b1;
      dm_we    = 1'b0;
    end else begin
      dm_addr  = cpu_addr;
      dm_wdata = cpu_wdata;
      dm_re    = cpu_re;
      dm_we    = cpu_we;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      pend_addr_q <= '0;
      starve_q    <= '0;
      dbg_rdata   <= '0;
      dbg_valid   <= 1'b0;
    end else begin
      state_q     <= state_d;
      pend_addr_q <= pend_addr_d;
      starve_q    <= starve_d;
      dbg_valid   <= dbg_grant;
      if (dbg_grant) dbg_rdata <= dm_rdata;
    end
  end

`ifdef DM_ARB_STATS_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt <= '0;
      dbg_cnt   <= '0;
    end else begin
      if (forced && stall_cnt != '1) stall_cnt <= stall_cnt + 16'd1;
      if (dbg_grant && dbg_cnt != '1) dbg_cnt <= dbg_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_dm_arbiter.sv
// Scenario bench for dm_arbiter with a behavioural DM and a queue of expected debug read data.
module tb_dm_arbiter;
  localparam int ADDR_W     = 10;
  localparam int DATA_W     = 32;
  localparam int STARVE_MAX = 4;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              cpu_re = 1'b0, cpu_we = 1'b0;
  logic [ADDR_W-1:0] cpu_addr = '0;
  logic [DATA_W-1:0] cpu_wdata = '0;
  logic [DATA_W-1:0] cpu_rdata;
  logic              cpu_stall;
  logic              dbg_req = 1'b0;
  logic [ADDR_W-1:0] dbg_addr = '0;
  logic              dbg_busy;
  logic [DATA_W-1:0] dbg_rdata;
  logic              dbg_valid;
  logic [ADDR_W-1:0] dm_addr;
  logic [DATA_W-1:0] dm_wdata;
  logic              dm_re, dm_we;
  logic [DATA_W-1:0] dm_rdata;
`ifdef DM_ARB_STATS_EN
  logic [15:0]       stall_cnt, dbg_cnt;
`endif

  logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];
  logic              pl_en = 1'b0;
  logic [ADDR_W-1:0] pl_addr = '0;
  logic [DATA_W-1:0] pl_data = '0;

  logic [DATA_W-1:0] sb [$];
  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (pl_en) mem[pl_addr] <= pl_data;
    else if (dm_we) mem[dm_addr] <= dm_wdata;
  end
  assign dm_rdata = mem[dm_addr];

  dm_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .STARVE_MAX(STARVE_MAX)) dut (
    .clk(clk), .rst(rst),
    .cpu_re(cpu_re), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
    .dbg_req(dbg_req), .dbg_addr(dbg_addr), .dbg_busy(dbg_busy),
    .dbg_rdata(dbg_rdata), .dbg_valid(dbg_valid),
    .dm_addr(dm_addr), .dm_wdata(dm_wdata), .dm_re(dm_re), .dm_we(dm_we),
    .dm_rdata(dm_rdata)
`ifdef DM_ARB_STATS_EN
    , .stall_cnt(stall_cnt), .dbg_cnt(dbg_cnt)
`endif
  );

  task automatic preload(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    @(posedge clk); #1;
    pl_en = 1'b1; pl_addr = a; pl_data = d;
    @(posedge clk); #1;
    pl_en = 1'b0;
  endtask

  task automatic test_reset();
    cpu_re = 1'b1; cpu_addr = 10'h03A; cpu_wdata = 32'h55;
    @(negedge clk);
    checks++; if (dbg_busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", dbg_busy); end
    checks++; if (dbg_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", dbg_valid); end
    checks++; if (dbg_rdata !== 32'h0) begin errors++; $display("FAIL reset_rdata: got %h want 0", dbg_rdata); end
    checks++; if (cpu_stall !== 1'b0) begin errors++; $display("FAIL reset_stall: got %b want 0", cpu_stall); end
    checks++; if (dm_addr !== 10'h03A || dm_re !== 1'b1 || dm_we !== 1'b0)
      begin errors++; $display("FAIL reset_cpu_grant: addr=%h re=%b we=%b want 03a 1 0", dm_addr, dm_re, dm_we); end
    checks++; if (cpu_rdata !== 32'h0000_3A3A) begin errors++; $display("FAIL reset_cpu_rdata: got %h want 00003a3a", cpu_rdata); end
    @(posedge clk); #1;
    rst = 1'b1; cpu_re = 1'b0;
  endtask

  task automatic test_free_slot(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] exp);
    int edges, stalls;
    logic [ADDR_W-1:0] g_addr;
    logic g_re, g_we, g_busy;
    logic [DATA_W-1:0] want;
    @(posedge clk); #1;
    cpu_re = 1'b0; cpu_we = 1'b0; dbg_req = 1'b1; dbg_addr = a;
    sb.push_back(exp);
    @(posedge clk); #1;
    dbg_req = 1'b0;
    stalls = 0; g_addr = '0; g_re = 1'b0; g_we = 1'b1; g_busy = 1'b0;
    for (edges = 1; edges <= 20; edges++) begin
      @(negedge clk);
      if (cpu_stall) stalls++;
      if (edges == 1) begin g_addr = dm_addr; g_re = dm_re; g_we = dm_we; g_busy = dbg_busy; end
      if (dbg_valid) break;
      @(posedge clk); #1;
    end
    want = sb.pop_front();
    checks++; if (edges !== 2) begin errors++; $display("FAIL free_latency: got %0d edges want 2", edges); end
    checks++; if (stalls !== 0) begin errors++; $display("FAIL free_stall: got %0d stall cycles want 0", stalls); end
    checks++; if (g_addr !== a || g_re !== 1'b1 || g_we !== 1'b0 || g_busy !== 1'b1)
      begin errors++; $display("FAIL free_grant: addr=%h re=%b we=%b busy=%b want %h 1 0 1", g_addr, g_re, g_we, g_busy, a); end
    checks++; if (dbg_rdata !== want) begin errors++; $display("FAIL free_data: got %h want %h", dbg_rdata, want); end
    checks++; if (dbg_busy !== 1'b0) begin errors++; $display("FAIL free_busy_clear: got %b want 0", dbg_busy); end
  endtask

  task automatic test_forced(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] exp);
    int edges, stalls, stall_edge;
    logic [ADDR_W-1:0] s_addr;
    logic s_we;
    logic [DATA_W-1:0] want;
    @(posedge clk); #1;
    cpu_re = 1'b1; cpu_we = 1'b0; cpu_addr = 10'h100; dbg_req = 1'b1; dbg_addr = a;
    sb.push_back(exp);
    @(posedge clk); #1;
    dbg_req = 1'b0;
    stalls = 0; stall_edge = 0; s_addr = '0; s_we = 1'b1;
    for (edges = 1; edges <= 20; edges++) begin
      @(negedge clk);
      if (cpu_stall) begin stalls++; stall_edge = edges; s_addr = dm_addr; s_we = dm_we; end
      if (dbg_valid) break;
      @(posedge clk); #1;
    end
    cpu_re = 1'b0;
    want = sb.pop_front();
    checks++; if (stalls !== 1) begin errors++; $display("FAIL forced_stall_count: got %0d want 1", stalls); end
    checks++; if (stall_edge !== STARVE_MAX + 1)
      begin errors++; $display("FAIL forced_stall_cycle: got %0d want %0d", stall_edge, STARVE_MAX + 1); end
    checks++; if (s_addr !== a || s_we !== 1'b0)
      begin errors++; $display("FAIL forced_port: addr=%h we=%b want %h 0", s_addr, s_we, a); end
    checks++; if (edges !== STARVE_MAX + 2)
      begin errors++; $display("FAIL forced_latency: got %0d want %0d", edges, STARVE_MAX + 2); end
    checks++; if (dbg_rdata !== want) begin errors++; $display("FAIL forced_data: got %h want %h", dbg_rdata, want); end
  endtask

  task automatic test_store_while_pending();
    int edges;
    logic [DATA_W-1:0] want;
    @(posedge clk); #1;
    cpu_re = 1'b1; cpu_addr = 10'h100; dbg_req = 1'b1; dbg_addr = 10'h020;
    sb.push_back(32'h1234_5678);
    @(posedge clk); #1;
    dbg_req = 1'b0; cpu_re = 1'b0; cpu_we = 1'b1; cpu_addr = 10'h020; cpu_wdata = 32'h1234_5678;
    @(negedge clk);
    checks++; if (dm_we !== 1'b1 || dm_addr !== 10'h020 || dm_wdata !== 32'h1234_5678 || cpu_stall !== 1'b0)
      begin errors++; $display("FAIL store_owner: we=%b addr=%h wdata=%h stall=%b want 1 020 12345678 0",
                               dm_we, dm_addr, dm_wdata, cpu_stall); end
    @(posedge clk); #1;
    cpu_we = 1'b0; cpu_wdata = '0;
    for (edges = 2; edges <= 20; edges++) begin
      @(negedge clk);
      if (dbg_valid) break;
      @(posedge clk); #1;
    end
    want = sb.pop_front();
    checks++; if (edges !== 3) begin errors++; $display("FAIL store_latency: got %0d want 3", edges); end
    checks++; if (dbg_rdata !== want) begin errors++; $display("FAIL store_readback: got %h want %h", dbg_rdata, want); end
  endtask

  task automatic test_req_hold();
    int pulses;
    logic [DATA_W-1:0] want;
    @(posedge clk); #1;
    cpu_re = 1'b1; cpu_addr = 10'h100; dbg_req = 1'b1; dbg_addr = 10'h005;
    sb.push_back(32'hDEAD_BEEF);
    @(posedge clk); #1; dbg_addr = 10'h010;
    @(posedge clk); #1; dbg_addr = 10'h020;
    @(posedge clk); #1; dbg_req = 1'b0; cpu_re = 1'b0;
    pulses = 0;
    want = sb.pop_front();
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (dbg_valid) begin
        pulses++;
        checks++; if (dbg_rdata !== want) begin errors++; $display("FAIL hold_data: got %h want %h", dbg_rdata, want); end
      end
      @(posedge clk); #1;
    end
    checks++; if (pulses !== 1) begin errors++; $display("FAIL hold_pulses: got %0d want 1", pulses); end
    checks++; if (dbg_busy !== 1'b0) begin errors++; $display("FAIL hold_busy: got %b want 0", dbg_busy); end
  endtask

  task automatic test_back_to_back();
    logic [DATA_W-1:0] want;
    @(posedge clk); #1;
    cpu_re = 1'b0; dbg_req = 1'b1; dbg_addr = 10'h010;
    sb.push_back(32'hA5A5_0010);
    @(posedge clk); #1;
    dbg_addr = 10'h005;
    sb.push_back(32'hDEAD_BEEF);
    @(posedge clk); #1;
    dbg_req = 1'b0;
    @(negedge clk);
    want = sb.pop_front();
    checks++; if (dbg_valid !== 1'b1 || dbg_rdata !== want || dbg_busy !== 1'b1)
      begin errors++; $display("FAIL b2b_first: valid=%b data=%h busy=%b want 1 %h 1", dbg_valid, dbg_rdata, dbg_busy, want); end
    @(posedge clk); #1;
    @(negedge clk);
    want = sb.pop_front();
    checks++; if (dbg_valid !== 1'b1 || dbg_rdata !== want || dbg_busy !== 1'b0)
      begin errors++; $display("FAIL b2b_second: valid=%b data=%h busy=%b want 1 %h 0", dbg_valid, dbg_rdata, dbg_busy, want); end
  endtask

  task automatic test_reset_mid_request();
    int pulses;
    @(posedge clk); #1;
    cpu_re = 1'b1; cpu_addr = 10'h100; dbg_req = 1'b1; dbg_addr = 10'h005;
    @(posedge clk); #1;
    dbg_req = 1'b0;
    @(posedge clk); #2;
    rst = 1'b0;
    #1;
    checks++; if (dbg_busy !== 1'b0 || dbg_valid !== 1'b0 || cpu_stall !== 1'b0 || dbg_rdata !== 32'h0)
      begin errors++; $display("FAIL async_reset: busy=%b valid=%b stall=%b data=%h want 0 0 0 0",
                               dbg_busy, dbg_valid, cpu_stall, dbg_rdata); end
    @(posedge clk); #1;
    rst = 1'b1; cpu_re = 1'b0;
    pulses = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (dbg_valid || dbg_busy) pulses++;
      @(posedge clk); #1;
    end
    checks++; if (pulses !== 0) begin errors++; $display("FAIL reset_drop: got %0d active cycles want 0", pulses); end
  endtask

`ifdef DM_ARB_STATS_EN
  task automatic test_stats();
    @(posedge clk); #1; rst = 1'b0;
    @(posedge clk); #1; rst = 1'b1;
    for (int i = 0; i < 3; i++) test_forced(10'h010, 32'hA5A5_0010);
    test_free_slot(10'h005, 32'hDEAD_BEEF);
    test_free_slot(10'h020, 32'h1234_5678);
    @(negedge clk);
    checks++; if (stall_cnt !== 16'd3) begin errors++; $display("FAIL stats_stall: got %0d want 3", stall_cnt); end
    checks++; if (dbg_cnt !== 16'd5) begin errors++; $display("FAIL stats_dbg: got %0d want 5", dbg_cnt); end
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    preload(10'h005, 32'hDEAD_BEEF);
    preload(10'h010, 32'hA5A5_0010);
    preload(10'h020, 32'h0BAD_F00D);
    preload(10'h03A, 32'h0000_3A3A);
    test_reset();
    test_free_slot(10'h005, 32'hDEAD_BEEF);
    test_forced(10'h010, 32'hA5A5_0010);
    test_store_while_pending();
    test_req_hold();
    test_back_to_back();
    test_reset_mid_request();
`ifdef DM_ARB_STATS_EN
    test_stats();
`endif
    checks++; if (sb.size() !== 0) begin errors++; $display("FAIL scoreboard_drain: got %0d entries want 0", sb.size()); end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
